// File: rtl/mem_dma.sv
// mem_dma: memory-side block-copy initiator for the RiSC-16 data memory port.
// It copies `count` words from `srcAddr` upward to `dstAddr` upward, one
// word at a time. Each word takes a READ cycle and then a WRITE cycle. A
// single DONE cycle follows the last word.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      one-cycle request, honoured only while idle
//   abort      ends the active transfer after the current cycle; no write issued
//   srcAddr    first source address, latched on an accepted start
//   dstAddr    first destination address, latched on an accepted start
//   count      number of words to copy, latched on an accepted start
//   busy       high while a transfer (including its DONE cycle) is in progress
//   done       one-cycle completion pulse
//   wordsDone  words written in the current or last transfer
//   memAddress address to the data memory
//   memDataIn  write data to the data memory
//   memWriteEn write strobe to the data memory
//   memDataOut combinational read data from the data memory
module mem_dma #(
  parameter int WORD_LEN  = 16,
  parameter int ADDR_LEN  = 16,
  parameter int CNT_LEN   = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_LEN-1:0] srcAddr,
  input  logic [ADDR_LEN-1:0] dstAddr,
  input  logic [CNT_LEN-1:0]  count,
  output logic                busy,
  output logic                done,
  output logic [CNT_LEN-1:0]  wordsDone,
  output logic [ADDR_LEN-1:0] memAddress,
  output logic [WORD_LEN-1:0] memDataIn,
  output logic                memWriteEn,
  input  logic [WORD_LEN-1:0] memDataOut
);

  localparam logic [ADDR_LEN-1:0] LP_STEP = ADDR_LEN'(ADDR_STEP);
  localparam logic [CNT_LEN-1:0]  LP_ONE  = CNT_LEN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_LEN-1:0] r_srcPtr;
  logic [ADDR_LEN-1:0] r_dstPtr;
  logic [CNT_LEN-1:0]  r_remaining;
  logic [CNT_LEN-1:0]  r_wordsDone;
  logic [WORD_LEN-1:0] r_buffer;
  // Last value actually written; drives memDataIn whenever not in WRITE.
  logic [WORD_LEN-1:0] r_lastWr;

  logic w_accept;
  logic w_rdStep;
  logic w_wrStep;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and memory-port decode
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    memAddress = '0;
    memDataIn  = r_lastWr;
    memWriteEn = 1'b0;
    w_accept   = 1'b0;
    w_rdStep   = 1'b0;
    w_wrStep   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // abort is ignored here, so start always wins when both are high
        if (start) begin
          w_accept = 1'b1;
          w_next   = (count != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        memAddress = r_srcPtr;
        if (abort) begin
          w_next = S_DONE;
        end else begin
          w_rdStep = 1'b1;
          w_next   = S_WRITE;
        end
      end
      S_WRITE: begin
        memAddress = r_dstPtr;
        memDataIn  = r_buffer;
        // Write strobe is withheld under abort so no partial word lands
        if (abort) begin
          w_next = S_DONE;
        end else begin
          memWriteEn = 1'b1;
          w_wrStep   = 1'b1;
          w_next     = (r_remaining == LP_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Transfer pointers, counters and data buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_srcPtr    <= '0;
      r_dstPtr    <= '0;
      r_remaining <= '0;
      r_wordsDone <= '0;
      r_buffer    <= '0;
      r_lastWr    <= '0;
    end else begin
      if (w_accept) begin
        r_srcPtr    <= srcAddr;
        r_dstPtr    <= dstAddr;
        r_remaining <= count;
        r_wordsDone <= '0;
      end
      if (w_rdStep) begin
        r_buffer <= memDataOut;
        r_srcPtr <= r_srcPtr + LP_STEP;
      end
      if (w_wrStep) begin
        // Pointers wrap modulo 2^ADDR_LEN by plain truncation
        r_dstPtr    <= r_dstPtr + LP_STEP;
        r_wordsDone <= r_wordsDone + LP_ONE;
        r_remaining <= r_remaining - LP_ONE;
        r_lastWr    <= r_buffer;
      end
    end
  end

  assign wordsDone = r_wordsDone;

endmodule
